// File: rtl/fifo_burst_drain.sv
// Drains a burst-mode FIFO into a frame buffer as fixed-length AXI-style write bursts.
// Addresses step linearly through the frame region and wrap to BASE_ADDR once per frame.
module fifo_burst_drain #(
  parameter int unsigned     WIDTH        = 24,
  parameter int unsigned     BURST        = 16,
  parameter int unsigned     AW           = 32,
  parameter logic [AW-1:0]   BASE_ADDR    = '0,
  parameter int unsigned     FRAME_BURSTS = 14400
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic             in_val_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic             aw_val_o,
  output logic [AW-1:0]    aw_addr_o,
  output logic [7:0]       aw_len_o,
  input  logic             aw_rdy_i,
  output logic             w_val_o,
  output logic [31:0]      w_data_o,
  output logic             w_last_o,
  input  logic             w_rdy_i,
  input  logic             b_val_i,
  input  logic [1:0]       b_resp_i,
  output logic             b_rdy_o,
  output logic             frame_o,
  output logic             err_o
);

  localparam int unsigned   BW         = $clog2(BURST);
  localparam int unsigned   CW         = $clog2(FRAME_BURSTS + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
  localparam logic [CW-1:0] LAST_BURST = CW'(FRAME_BURSTS - 1);
  localparam logic [AW-1:0] ADDR_STEP  = AW'(4 * BURST);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   burst_q, burst_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            sync_q, sync_d;
  logic            err_q, err_d;
  logic            frame_q, frame_d;
  logic            last_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      burst_q <= '0;
      beat_q  <= '0;
      sync_q  <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      sync_q  <= sync_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    sync_d   = sync_q | sync_i;
    err_d    = err_q;
    frame_d  = 1'b0;
    aw_val_o = 1'b0;
    in_rdy_o = 1'b0;
    w_val_o  = 1'b0;
    w_data_o = '0;
    w_last_o = 1'b0;
    b_rdy_o  = 1'b0;

    unique case (state_q)
      // A sync arriving in this very cycle is honoured too, so it never waits a whole burst.
      IDLE: begin
        if (sync_q || sync_i) begin
          addr_d  = BASE_ADDR;
          burst_d = '0;
          sync_d  = 1'b0;
        end
        if (in_val_i) state_d = ADDR;
      end
      ADDR: begin
        aw_val_o = 1'b1;
        if (aw_rdy_i) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        w_val_o  = in_val_i;
        in_rdy_o = w_rdy_i;
        w_data_o = 32'(in_data_i);
        w_last_o = last_beat;
        if (in_val_i && w_rdy_i) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        b_rdy_o = 1'b1;
        if (b_val_i) begin
          if (b_resp_i != 2'd0) err_d = 1'b1;
          if (burst_q == LAST_BURST) begin
            burst_d = '0;
            addr_d  = BASE_ADDR;
            frame_d = 1'b1;
          end else begin
            burst_d = burst_q + 1'b1;
            addr_d  = addr_q + ADDR_STEP;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_addr_o = addr_q;
  assign aw_len_o  = 8'(BURST - 1);
  assign frame_o   = frame_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: acts as FIFO and responder, scoreboards every handshake
// against a transaction-level model of frame addressing, beat order and responses.
module tb_fifo_burst_drain;

  localparam int          WIDTH = 24;
  localparam int          BURST = 4;
  localparam int          AW    = 32;
  localparam int          FB    = 3;
  localparam logic [31:0] BASE  = 32'h1000;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        syncPulse = 1'b0;
  logic        inVal = 1'b0;
  logic [23:0] inData;
  logic        inRdy;
  logic        awVal;
  logic [31:0] awAddr;
  logic [7:0]  awLen;
  logic        awRdy = 1'b0;
  logic        wVal;
  logic [31:0] wData;
  logic        wLast;
  logic        wRdy = 1'b0;
  logic        bVal = 1'b0;
  logic [1:0]  bResp = 2'd0;
  logic        bRdy;
  logic        frameOut;
  logic        errOut;

  fifo_burst_drain #(
    .WIDTH(WIDTH), .BURST(BURST), .AW(AW), .BASE_ADDR(BASE), .FRAME_BURSTS(FB)
  ) dut (
    .clk_i(clk), .rst_ni(rstN), .sync_i(syncPulse),
    .in_val_i(inVal), .in_data_i(inData), .in_rdy_o(inRdy),
    .aw_val_o(awVal), .aw_addr_o(awAddr), .aw_len_o(awLen), .aw_rdy_i(awRdy),
    .w_val_o(wVal), .w_data_o(wData), .w_last_o(wLast), .w_rdy_i(wRdy),
    .b_val_i(bVal), .b_resp_i(bResp), .b_rdy_o(bRdy),
    .frame_o(frameOut), .err_o(errOut)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  bit dataPhase = 0;
  bit respPhase = 0;
  int beatInBurst = 0;
  int frameIdx = 0;
  bit syncSeen = 0;
  bit expFrame = 0;
  bit expErr = 0;
  int beatsSeen = 0;
  int popCount = 0;
  int burstsDone = 0;
  int dutFrames = 0;
  int badBurst = 5;
  bit popFlag = 0;
  bit lastFlag = 0;
  bit bFlag = 0;
  bit respPending = 0;
  bit awHs, wHs, bHs;
  logic [31:0] awAddrLog[$];
  int awCycleLog[$];

  function automatic logic [23:0] genData(int k);
    return 24'hF00000 + 24'(k * 3);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic timeoutFail(string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL timeout_%s: wait bound expired (cycle %0d)", name, cycle);
  endtask

  // Scoreboard: checks outputs mid-cycle, then advances the transaction model for the coming edge.
  always @(negedge clk) begin
    cycle++;
    if (!rstN) begin
      checkOutput("rst_aw_val", 32'(awVal), 32'd0);
      checkOutput("rst_w_val", 32'(wVal), 32'd0);
      checkOutput("rst_in_rdy", 32'(inRdy), 32'd0);
      checkOutput("rst_w_last", 32'(wLast), 32'd0);
      checkOutput("rst_b_rdy", 32'(bRdy), 32'd0);
      checkOutput("rst_frame", 32'(frameOut), 32'd0);
      checkOutput("rst_err", 32'(errOut), 32'd0);
      checkOutput("rst_w_data", wData, 32'd0);
      checkOutput("rst_aw_addr", awAddr, BASE);
      checkOutput("rst_aw_len", 32'(awLen), 32'(BURST - 1));
      dataPhase = 0; respPhase = 0; beatInBurst = 0; frameIdx = 0;
      syncSeen = 0; expFrame = 0; expErr = 0;
    end else begin
      if (frameOut) dutFrames++;
      checkOutput("frame", 32'(frameOut), 32'(expFrame));
      checkOutput("err", 32'(errOut), 32'(expErr));
      checkOutput("aw_len", 32'(awLen), 32'(BURST - 1));
      checkOutput("w_val", 32'(wVal), dataPhase ? 32'(inVal) : 32'd0);
      checkOutput("in_rdy", 32'(inRdy), dataPhase ? 32'(wRdy) : 32'd0);
      checkOutput("w_last", 32'(wLast), 32'(dataPhase && beatInBurst == BURST - 1));
      checkOutput("b_rdy", 32'(bRdy), 32'(respPhase));
      if (dataPhase || respPhase) checkOutput("aw_val_busy", 32'(awVal), 32'd0);
      if (!dataPhase) checkOutput("w_data_idle", wData, 32'd0);

      awHs = awVal && awRdy;
      wHs  = wVal && wRdy;
      bHs  = bVal && bRdy;
      expFrame = 0;
      if (awHs) begin
        if (syncSeen) begin
          frameIdx = 0;
          syncSeen = 0;
        end
        checkOutput("aw_addr", awAddr, BASE + 32'(4 * BURST * frameIdx));
        awAddrLog.push_back(awAddr);
        awCycleLog.push_back(cycle);
        dataPhase = 1;
        beatInBurst = 0;
      end
      if (wHs && dataPhase) begin
        checkOutput("w_data", wData, {8'h00, genData(beatsSeen)});
        beatsSeen++;
        beatInBurst++;
        if (beatInBurst == BURST) begin
          dataPhase = 0;
          respPhase = 1;
          lastFlag = 1;
        end
      end
      if (bHs && respPhase) begin
        if (bResp != 2'd0) expErr = 1;
        respPhase = 0;
        burstsDone++;
        bFlag = 1;
        if (frameIdx == FB - 1) begin
          frameIdx = 0;
          expFrame = 1;
        end else begin
          frameIdx++;
        end
      end
      popFlag = inVal && inRdy;
      if (syncPulse) syncSeen = 1;
    end
  end

  // One clock of the FIFO and responder models; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bFlag) respPending = 0;
    if (lastFlag) respPending = 1;
    bFlag = 0;
    lastFlag = 0;
    if (popFlag) popCount++;
    popFlag = 0;
    bVal = respPending;
    bResp = (burstsDone == badBurst) ? 2'd2 : 2'd0;
    inData = genData(popCount);
  endtask

  task automatic waitAw(int n);
    for (int i = 0; i < 300 && awAddrLog.size() < n; i++) tick();
    if (awAddrLog.size() < n) timeoutFail("aw");
  endtask

  task automatic waitBeat(int b);
    for (int i = 0; i < 100 && !(dataPhase && beatInBurst == b); i++) tick();
    if (!(dataPhase && beatInBurst == b)) timeoutFail("beat");
  endtask

  task automatic waitDone(int n);
    for (int i = 0; i < 300 && burstsDone < n; i++) tick();
    if (burstsDone < n) timeoutFail("resp");
  endtask

  task automatic applyStimulus();
    inData = genData(0);
    repeat (3) tick();
    rstN = 1'b1;
    inVal = 1'b1;
    awRdy = 1'b1;
    wRdy = 1'b1;

    // Full-speed bursts through a frame wrap, then a 3-cycle w_rdy stall at beat 2.
    waitAw(4);
    waitBeat(2);
    wRdy = 1'b0;
    repeat (3) tick();
    wRdy = 1'b1;

    // Sync mid-burst: this burst keeps 0x1010, the next one restarts at the base.
    waitAw(5);
    waitBeat(1);
    syncPulse = 1'b1;
    tick();
    syncPulse = 1'b0;

    // FIFO runs dry for two cycles mid-burst.
    waitAw(7);
    waitBeat(1);
    inVal = 1'b0;
    repeat (2) tick();
    inVal = 1'b1;

    // Reset during beat 1 of the burst at 0x1020.
    waitAw(8);
    checkOutput("err_sticky", 32'(errOut), 32'd1);
    waitBeat(1);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("async_w_val", 32'(wVal), 32'd0);
    checkOutput("async_in_rdy", 32'(inRdy), 32'd0);
    checkOutput("async_err", 32'(errOut), 32'd0);
    respPending = 0;
    bVal = 1'b0;
    popFlag = 0;
    lastFlag = 0;
    bFlag = 0;
    repeat (2) tick();
    rstN = 1'b1;

    waitDone(9);
    inVal = 1'b0;
    repeat (4) tick();
  endtask

  task automatic checkFinal();
    logic [31:0] expAddr[10];
    expAddr = '{32'h1000, 32'h1010, 32'h1020, 32'h1000, 32'h1010,
                32'h1000, 32'h1010, 32'h1020, 32'h1000, 32'h1010};
    checkOutput("aw_count", 32'(awAddrLog.size()), 32'd10);
    for (int i = 0; i < 10 && i < awAddrLog.size(); i++)
      checkOutput($sformatf("addr_log_%0d", i), awAddrLog[i], expAddr[i]);
    if (awCycleLog.size() >= 5) begin
      checkOutput("period_0_1", 32'(awCycleLog[1] - awCycleLog[0]), 32'd7);
      checkOutput("period_1_2", 32'(awCycleLog[2] - awCycleLog[1]), 32'd7);
      checkOutput("period_stall", 32'(awCycleLog[4] - awCycleLog[3]), 32'd10);
    end else begin
      timeoutFail("period_log");
    end
    checkOutput("frame_pulses", 32'(dutFrames), 32'd1);
    checkOutput("pop_total", 32'(popCount), 32'd37);
    checkOutput("beats_total", 32'(beatsSeen), 32'd37);
    checkOutput("final_idle_aw_val", 32'(awVal), 32'd0);
  endtask

  initial begin
    applyStimulus();
    checkFinal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
# fifo_burst_drain

Read-side companion of the burst-mode pixel FIFO. It waits until the FIFO reports at least BURST entries buffered. It then issues one fixed-length write burst per BURST beats to a frame buffer over an AXI-style address/data/response channel triplet. Addresses step linearly through a frame region and wrap to BASE_ADDR after FRAME_BURSTS bursts.

## Interface
Parameters:
- WIDTH, 24, FIFO data width; must be ≤ 32.
- BURST, 16, beats per burst; 2..256; must equal the BURST of the feeding FIFO.
- AW, 32, address width.
- BASE_ADDR, 0, first byte address of the frame region; 4·BURST-aligned.
- FRAME_BURSTS, 14400, bursts per frame; ≥ 1.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- sync_i  in  1  one-cycle pulse; restart addressing at BASE_ADDR at the next burst boundary.
- in_val_i  in  1  FIFO out_val: at least BURST entries available at burst start; per-beat valid inside a burst.
- in_data_i  in  WIDTH  FIFO data.
- in_rdy_o  out  1  pop strobe to FIFO.
- aw_val_o  out  1  burst address valid.
- aw_addr_o  out  AW  burst byte address.
- aw_len_o  out  8  BURST-1.
- aw_rdy_i  in  1  address accepted.
- w_val_o  out  1  data beat valid.
- w_data_o  out  32  in_data_i zero-extended.
- w_last_o  out  1  final beat of burst.
- w_rdy_i  in  1  data beat accepted.
- b_val_i  in  1  write response valid.
- b_resp_i  in  2  response code; 0 = OK.
- b_rdy_o  out  1  response accepted.
- frame_o  out  1  one-cycle pulse after the last burst of a frame is acknowledged.
- err_o  out  1  sticky; set on any b_resp_i ≠ 0.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If a sync is pending, clear addr to BASE_ADDR and clear the burst counter and the sync flag.
  - Then, if in_val_i = 1, go to ADDR.
- ADDR: aw_val_o = 1 with aw_addr_o = current addr. Hold addr until aw_rdy_i, then go to DATA with beat counter = 0.
- DATA:
  - w_val_o = in_val_i; in_rdy_o = w_rdy_i; w_data_o = {zeros, in_data_i}.
  - A beat transfers when in_val_i && w_rdy_i. The counter increments only on a transfer.
  - w_last_o = (beat counter == BURST-1). A transfer with w_last_o goes to RESP.
  - Stalls on either side are legal mid-burst. A beat is never dropped or duplicated.
- RESP: b_rdy_o = 1. On b_val_i:
  - Set err_o if b_resp_i ≠ 0.
  - addr += 4·BURST.
  - Increment the burst counter. At FRAME_BURSTS-1, wrap: counter → 0, addr → BASE_ADDR, frame_o = 1 for one cycle.
  - Return to IDLE.
- sync_i is latched into a pending flag in any state and consumed only in IDLE. A burst in flight always completes at its original address.
- Outputs are 0 outside their own state: aw_val_o outside ADDR; w_val_o, in_rdy_o and w_last_o outside DATA; b_rdy_o outside RESP.
- err_o clears only on reset.

## Timing
- Reset (rst_ni low, asynchronous):
  - State IDLE; addr = BASE_ADDR; counters 0; sync flag 0.
  - All outputs 0, except aw_addr_o = BASE_ADDR and aw_len_o = BURST-1.
- Reset mid-burst abandons the burst immediately. No further beats are issued. The downstream side is reset together with this block.
- Latency from in_val_i rising in IDLE to aw_val_o is 1 cycle.
- Minimum burst period is BURST+3 cycles: IDLE 1, ADDR 1, DATA BURST, RESP 1.
- The data path is combinational in DATA: w_val_o follows in_val_i and in_rdy_o follows w_rdy_i in the same cycle. in_rdy_o never asserts outside DATA.
- A b_val_i arriving before RESP is not acknowledged. It is held by the responder until RESP.
- A sync_i coinciding with a frame wrap in RESP is applied: the next burst uses BASE_ADDR, which is the same result either way.

## Test plan
- BURST=4, BASE_ADDR=0x1000, FIFO always valid, all ready -> bursts at 0x1000, 0x1010, 0x1020; w_last_o on the 4th beat of each; period 7 cycles.
- w_rdy_i low for 3 cycles mid-beat 2 -> in_rdy_o low for the same 3 cycles; exactly 4 pops per burst; data order preserved.
- FRAME_BURSTS=3 -> 3rd response gives a frame_o pulse; next aw_addr_o = 0x1000.
- sync_i pulsed during DATA of the burst at 0x1010 -> that burst completes at 0x1010; the next burst goes to 0x1000.
- b_resp_i=2 on one burst -> err_o goes high and stays high; addressing continues normally.
- rst_ni low during DATA beat 1 -> all outputs 0 asynchronously; after release, the first aw_addr_o = 0x1000.
